// File: rtl/keyed_seq_reader.sv
// keyed_seq_reader: key-unlocked LFSR serial responder on qualified bus reads
module keyed_seq_reader #(
  parameter int STATE_W = 6,
  parameter logic [STATE_W-1:0] TAPS = 6'b110000,
  parameter logic [STATE_W-1:0] SEED = 6'b000001,
  parameter int KEY_LEN = 4,
  parameter logic [KEY_LEN*4-1:0] KEY = 16'h39C6,
  parameter logic [3:0] RELOCK = 4'hF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sser_n,
  input  logic [13:0] ba,
  input  logic        br_w,
  input  logic        acc_stb,
  output logic        sdrd,
  output logic        sdrd_oe,
  output logic        unlocked,
  output logic [2:0]  key_idx
);
  typedef enum logic {LOCKED, STREAM} state_t;
  state_t state, state_nx;
  logic [STATE_W-1:0] lfsr, lfsr_nx;
  logic [2:0] key_nx;
  logic sdrd_nx, win, qacc;
  logic [3:0] nib, cur_nib, first_nib;
  logic unused_ba;
  assign unused_ba = ^{ba[11:8], ba[3:0]};
  assign win = ~sser_n & (ba[13:12] == 2'b01) & br_w;
  assign qacc = acc_stb & win;
  assign sdrd_oe = win;
  assign unlocked = state == STREAM;
  assign nib = ba[7:4];
  assign first_nib = KEY[KEY_LEN*4-1 -: 4];
  assign cur_nib = 4'(KEY >> (4 * (KEY_LEN - 1 - int'(key_idx))));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LOCKED;
      key_idx <= '0;
      lfsr <= SEED;
      sdrd <= 1'b0;
    end else begin
      state <= state_nx;
      key_idx <= key_nx;
      lfsr <= lfsr_nx;
      sdrd <= sdrd_nx;
    end
  end
  always_comb begin
    state_nx = state;
    key_nx = key_idx;
    lfsr_nx = lfsr;
    sdrd_nx = sdrd;
    if (qacc) begin
      if (state == LOCKED) begin
        sdrd_nx = 1'b0;
        if (nib == cur_nib) begin
          if (key_idx == 3'(KEY_LEN - 1)) begin
            state_nx = STREAM;
            key_nx = '0;
            lfsr_nx = SEED;
          end else key_nx = key_idx + 3'd1;
        end else key_nx = (nib == first_nib) ? 3'd1 : 3'd0;
      end else if (nib == RELOCK) begin
        sdrd_nx = 1'b0;
        state_nx = LOCKED;
        key_nx = '0;
        lfsr_nx = SEED;
      end else if (lfsr == '0) begin
        sdrd_nx = 1'b0;
        lfsr_nx = SEED;
      end else begin
        sdrd_nx = lfsr[STATE_W-1];
        lfsr_nx = {lfsr[STATE_W-2:0], ^(lfsr & TAPS)};
      end
    end
  end
endmodule
